// File: rtl/ds_skid_if.sv
// Valid/ready stream interface shared by the ds_skid ports.
package ds_if_pkg;
  // Flow-control style carried by an interface instance.
  typedef enum logic [1:0] {
    FC_NONE = 2'd0,
    FC_FWD  = 2'd1,
    FC_BI   = 2'd2
  } fc_e;
endpackage

interface ds_if #(
  parameter type             DTYPE = logic [7:0],
  parameter ds_if_pkg::fc_e  FC    = ds_if_pkg::FC_BI
) ();
  logic vld;
  logic rdy;
  DTYPE data;
  logic xfer;

  // A beat moves when both sides agree in the same cycle.
  assign xfer = vld & rdy;

  modport slv (input vld, input data, input xfer, output rdy);
  modport mst (output vld, output data, input rdy, input xfer);
endinterface

// File: rtl/ds_skid.sv
// Two-entry skid buffer: registered valid/data towards m, registered ready towards s.
module ds_skid #(
  parameter type DTYPE = logic [7:0]
) (
  input  logic       clk,
  input  logic       rst_n,
  ds_if.slv          s,
  ds_if.mst          m,
  output logic [1:0] lvl
);

  // Both ends must use bidirectional flow control.
  if (s.FC != ds_if_pkg::FC_BI) begin : g_bad_fc_s
    $error("ds_skid: port s must be FC_BI");
  end
  if (m.FC != ds_if_pkg::FC_BI) begin : g_bad_fc_m
    $error("ds_skid: port m must be FC_BI");
  end

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e     state_q, state_d;
  DTYPE       main_q, main_d;
  DTYPE       skid_q, skid_d;
  logic       rdy_q, rdy_d;
  logic       vld_q, vld_d;
  logic [1:0] lvl_q, lvl_d;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (s.xfer) begin
          main_d  = s.data;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (s.xfer && !m.xfer) begin
          skid_d  = s.data;
          state_d = ST_FULL;
        end else if (!s.xfer && m.xfer) begin
          state_d = ST_EMPTY;
        end else if (s.xfer && m.xfer) begin
          main_d  = s.data;
        end
      end
      ST_FULL: begin
        // s.rdy is low here, so only the downstream side can move.
        if (m.xfer) begin
          main_d  = skid_q;
          state_d = ST_BUSY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    rdy_d = (state_d != ST_FULL);
    vld_d = (state_d != ST_EMPTY);
    unique case (state_d)
      ST_EMPTY: lvl_d = 2'd0;
      ST_BUSY:  lvl_d = 2'd1;
      ST_FULL:  lvl_d = 2'd2;
      default:  lvl_d = 2'd0;
    endcase
  end

  // State and output registers; reset flushes both entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      rdy_q   <= 1'b0;
      vld_q   <= 1'b0;
      lvl_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      rdy_q   <= rdy_d;
      vld_q   <= vld_d;
      lvl_q   <= lvl_d;
    end
  end

  assign s.rdy  = rdy_q;
  assign m.vld  = vld_q;
  assign m.data = main_q;
  assign lvl    = lvl_q;

endmodule
